// File: rtl/saw_if.sv
// saw_if: sample stream in, measurement results out, for saw_analyzer
interface saw_if #(
    parameter int PER_W = 16
);
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [PER_W-1:0] m_period;
    logic [7:0]       m_min;
    logic [7:0]       m_max;
    logic             locked;
    logic             timeout;
    logic [7:0]       drop_cnt;
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_period, m_min, m_max, locked, timeout, drop_cnt
    );
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_period, m_min, m_max, locked, timeout, drop_cnt
    );
endinterface

// File: rtl/saw_analyzer.sv
// saw_analyzer: sawtooth period/lock/timeout analyzer; min/max tracking built only with SAW_ANALYZER_MINMAX_EN
module saw_analyzer #(
    parameter int DROP_TH  = 128,
    parameter int PER_W    = 16,
    parameter int LOCK_CNT = 3
) (
    input logic  clk,
    input logic  rst,
    saw_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK = MW'(LOCK_CNT);
    localparam logic [PER_W-1:0] CNT_LAST = ~PER_W'(1);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t           state;
    logic [7:0]       prev;
    logic             prev_valid;
    logic [PER_W-1:0] cnt;
    logic [PER_W-1:0] last_period;
    logic [PER_W-1:0] m_period;
    logic [MW-1:0]    match;
    logic             m_valid;
    logic             locked;
    logic             timeout;
    logic [7:0]       drop_cnt;
    logic [8:0]       diff;
    logic             acc;
    logic             wrap;
    logic             res;
    logic             load;
    always_comb begin
        acc  = bus.s_valid;
        diff = {1'b0, prev} - {1'b0, bus.s_data};
        wrap = acc && prev_valid && !diff[8] && diff >= 9'(DROP_TH);
        res  = wrap && state == MEASURE;
        load = res && (!m_valid || bus.m_ready);
    end
    always_ff @(posedge clk) begin
        timeout <= 1'b0;
        if (rst) begin
            state       <= IDLE;
            prev        <= '0;
            prev_valid  <= 1'b0;
            cnt         <= '0;
            last_period <= '0;
            match       <= '0;
            locked      <= 1'b0;
            m_valid     <= 1'b0;
            m_period    <= '0;
            drop_cnt    <= '0;
        end else begin
            locked <= match >= LOCK;
            if (m_valid && bus.m_ready) m_valid <= 1'b0;
            if (acc) begin
                prev       <= bus.s_data;
                prev_valid <= 1'b1;
                if (wrap) begin
                    state <= MEASURE;
                    cnt   <= PER_W'(1);
                end else if (state == MEASURE) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        match   <= '0;
                        locked  <= 1'b0;
                    end
                end
                if (res) begin
                    last_period <= cnt;
                    if (cnt == last_period) match <= (match < LOCK) ? match + 1'b1 : match;
                    else begin
                        match  <= MW'(1);
                        locked <= 1'b0;
                    end
                    if (load) begin
                        m_valid  <= 1'b1;
                        m_period <= cnt;
                    end else drop_cnt <= (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 1'b1;
                end
            end
        end
    end
`ifdef SAW_ANALYZER_MINMAX_EN
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] m_min;
    logic [7:0] m_max;
    always_ff @(posedge clk) begin
        if (rst) begin
            mn    <= '0;
            mx    <= '0;
            m_min <= '0;
            m_max <= '0;
        end else begin
            if (wrap) begin
                mn <= bus.s_data;
                mx <= bus.s_data;
            end else if (acc && state == MEASURE) begin
                mn <= (bus.s_data < mn) ? bus.s_data : mn;
                mx <= (bus.s_data > mx) ? bus.s_data : mx;
            end
            if (load) begin
                m_min <= mn;
                m_max <= mx;
            end
        end
    end
    assign bus.m_min = m_min;
    assign bus.m_max = m_max;
`else
    assign bus.m_min = 8'h00;
    assign bus.m_max = 8'hFF;
`endif
    assign bus.s_ready  = 1'b1;
    assign bus.m_valid  = m_valid;
    assign bus.m_period = m_period;
    assign bus.locked   = locked;
    assign bus.timeout  = timeout;
    assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_saw_analyzer.sv
// tb_saw_analyzer: scoreboard bench for saw_analyzer (default and PER_W=8 instances)
module tb_saw_analyzer;
`ifdef SAW_ANALYZER_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    typedef struct packed {
        logic [15:0] per;
        logic [7:0]  mn;
        logic [7:0]  mx;
    } exp_t;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   to_n;
    int   mv_n;
    exp_t sb[$];
    exp_t mon_e;
    saw_if bus ();
    saw_if #(.PER_W(8)) b8 ();
    saw_analyzer u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    saw_analyzer #(.PER_W(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic void push(input int per, input logic [7:0] mn, input logic [7:0] mx);
        sb.push_back('{16'(per), MM ? mn : 8'h00, MM ? mx : 8'hFF});
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("sb_period", 32'(bus.m_period), 32'(mon_e.per));
                chk("sb_min", 32'(bus.m_min), 32'(mon_e.mn));
                chk("sb_max", 32'(bus.m_max), 32'(mon_e.mx));
            end
        end
    end
    task automatic step(input logic v, input logic [7:0] d);
        bus.s_valid = v;
        bus.s_data  = d;
        @(posedge clk);
        #1;
    endtask
    task automatic step8(input logic [7:0] d);
        b8.s_valid = 1'b1;
        b8.s_data  = d;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        b8.s_valid  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    task automatic ramp(input int len, input int per, input logic lk);
        for (int k = 0; k < len; k++) begin
            if (k == 0 && per != 0) push(per, 8'h00, 8'((per - 1) * 2));
            step(1'b1, 8'(k * 2));
            if (k == 0 && per != 0) chk("latency_valid", 32'(bus.m_valid), 1);
            if (k == 5) chk("locked", 32'(bus.locked), 32'(lk));
        end
    endtask
    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        b8.s_valid  = 1'b0;
        b8.s_data   = '0;
        b8.m_ready  = 1'b1;
        do_reset();
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 0);
        chk("rst_m_period", 32'(bus.m_period), 0);
        chk("rst_m_min", 32'(bus.m_min), 0);
        chk("rst_m_max", 32'(bus.m_max), MM ? 32'h00 : 32'hFF);
        chk("s_ready", 32'(bus.s_ready), 1);
        // periods 128,128,128,100: lock rises after the third, falls after the 100
        ramp(128, 0, 1'b0);
        ramp(128, 0, 1'b0);
        ramp(128, 128, 1'b0);
        ramp(128, 128, 1'b0);
        ramp(100, 128, 1'b1);
        push(100, 8'h00, 8'hC6);
        step(1'b1, 8'h00);
        chk("p100_valid", 32'(bus.m_valid), 1);
        chk("p100_period", 32'(bus.m_period), 100);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("lock_fall", 32'(bus.locked), 0);
        chk("sb_drain_lock", 32'(sb.size()), 0);
        do_reset();
        step(1'b1, 8'h80);
        step(1'b1, 8'h01);
        step(1'b1, 8'h80);
        step(1'b1, 8'h00);
        chk("th_enter_no_result", 32'(bus.m_valid), 0);
        step(1'b1, 8'h40);
        step(1'b1, 8'h80);
        push(3, 8'h00, 8'h80);
        step(1'b1, 8'h00);
        chk("th_wrap_valid", 32'(bus.m_valid), 1);
        chk("th_wrap_period", 32'(bus.m_period), 3);
        step(1'b0, 8'h00);
        chk("sb_drain_th", 32'(sb.size()), 0);
        do_reset();
        bus.m_ready = 1'b0;
        ramp(128, 0, 1'b0);
        ramp(128, 0, 1'b0);
        ramp(100, 128, 1'b0);
        step(1'b1, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("hold_valid", 32'(bus.m_valid), 1);
        chk("hold_period", 32'(bus.m_period), 128);
        chk("hold_max", 32'(bus.m_max), MM ? 32'hFE : 32'hFF);
        chk("drop_cnt_1", 32'(bus.drop_cnt), 1);
        bus.m_ready = 1'b1;
        step(1'b0, 8'h00);
        chk("hold_released", 32'(bus.m_valid), 0);
        chk("sb_drain_hold", 32'(sb.size()), 0);
        do_reset();
        bus.m_ready = 1'b0;
        ramp(128, 0, 1'b0);
        ramp(128, 0, 1'b0);
        ramp(100, 128, 1'b0);
        bus.m_ready = 1'b1;
        push(100, 8'h00, 8'hC6);
        step(1'b1, 8'h00);
        chk("same_cycle_drop", 32'(bus.drop_cnt), 0);
        chk("same_cycle_valid", 32'(bus.m_valid), 1);
        chk("same_cycle_period", 32'(bus.m_period), 100);
        step(1'b0, 8'h00);
        chk("sb_drain_same", 32'(sb.size()), 0);
        do_reset();
        bus.m_ready = 1'b0;
        ramp(128, 0, 1'b0);
        ramp(128, 0, 1'b0);
        step(1'b1, 8'h00);
        for (int k = 1; k < 50; k++) step(1'b1, 8'(k * 2));
        rst = 1'b1;
        step(1'b1, 8'h64);
        rst = 1'b0;
        chk("rstmid_valid", 32'(bus.m_valid), 0);
        chk("rstmid_drop", 32'(bus.drop_cnt), 0);
        chk("rstmid_locked", 32'(bus.locked), 0);
        bus.m_ready = 1'b1;
        step(1'b1, 8'h80);
        step(1'b1, 8'h00);
        chk("rstmid_reenter", 32'(bus.m_valid), 0);
        step(1'b1, 8'h40);
        step(1'b1, 8'h00);
        step(1'b1, 8'h90);
        push(4, 8'h00, 8'h90);
        step(1'b1, 8'h00);
        chk("rstmid_result", 32'(bus.m_valid), 1);
        step(1'b0, 8'h00);
        chk("sb_drain_rst", 32'(sb.size()), 0);
        bus.s_valid = 1'b0;
        to_n = 0;
        mv_n = 0;
        step8(8'h80);
        step8(8'h00);
        for (int i = 1; i <= 254; i++) begin
            step8(8'h40);
            to_n += int'(b8.timeout);
            mv_n += int'(b8.m_valid);
            if (i == 254) chk("timeout_pulse", 32'(b8.timeout), 1);
        end
        step8(8'h40);
        to_n += int'(b8.timeout);
        chk("timeout_count", 32'(to_n), 1);
        chk("timeout_no_valid", 32'(mv_n), 0);
        chk("timeout_locked", 32'(b8.locked), 0);
        step8(8'hC0);
        step8(8'h00);
        chk("timeout_idle_reenter", 32'(b8.m_valid), 0);
        step8(8'h80);
        step8(8'h00);
        chk("timeout_next_valid", 32'(b8.m_valid), 1);
        chk("timeout_next_period", 32'(b8.m_period), 2);
        b8.s_valid = 1'b0;
        chk("sb_drain_final", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/saw_analyzer.md
SAW_ANALYZER -- requirements
Module: saw_analyzer

Interface
REQ-001 SHALL have parameter DROP_TH, default 128: minimum unsigned sample drop (prev - cur) that counts as a wrap.
REQ-002 SHALL have parameter PER_W, default 16: width of the period counter and period output.
REQ-003 SHALL have parameter LOCK_CNT, default 3: number of consecutive identical periods required to assert lock.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_valid  in  1  input sample valid.
REQ-007 s_data  in  8  unsigned sawtooth sample.
REQ-008 s_ready  out  1  constant 1; a sample is accepted on every cycle with s_valid=1.
REQ-009 m_valid  out  1  result valid.
REQ-010 m_ready  in  1  result accepted when m_valid and m_ready are both 1.
REQ-011 m_period  out  PER_W  samples from one wrap up to, but not including, the next wrap.
REQ-012 m_min, m_max  out  8 each  minimum and maximum sample over the measured period.
REQ-013 locked  out  1  period is stable.
REQ-014 timeout  out  1  one-cycle pulse when the period counter saturates.
REQ-015 drop_cnt  out  8  saturating count of discarded results.

Function
REQ-016 A wrap SHALL be an accepted sample with prev_valid=1 and (prev - cur) >= DROP_TH.
- Compute prev - cur as a 9-bit unsigned difference; no wrap when prev < cur.
- prev is the previous accepted sample; prev_valid is set by the first accepted sample.
REQ-017 FSM SHALL have two states, IDLE and MEASURE, entering IDLE after reset.
REQ-018 In IDLE, a wrap SHALL move the FSM to MEASURE and set cnt=1 and min=max=cur; non-wrap samples update only prev.
REQ-019 In MEASURE, an accepted non-wrap sample SHALL increment cnt and update min and max.
REQ-020 In MEASURE, a wrap SHALL produce a result {cnt, min, max} and restart measurement with cnt=1 and min=max=cur.
REQ-021 Latency SHALL be fixed: when the wrap sample is accepted in cycle N, m_valid is 1 and the new result is on the outputs in cycle N+1.
REQ-022 The output register SHALL be one deep and SHALL hold its values until the handshake completes.
- A new result arriving while m_valid=1 and m_ready=0 is discarded and drop_cnt increments.
- If the handshake completes in the same cycle a new result arrives, the new result is loaded and nothing is dropped.
REQ-023 Lock tracking SHALL use a match counter, updated on every produced result, including discarded ones.
- Period equal to the previous period: increment the match counter.
- Period differs: reset the match counter to 1 and clear locked.
- locked=1 from the cycle after the match counter reaches LOCK_CNT.
REQ-024 When cnt reaches 2^PER_W-1 in MEASURE with no wrap, the block SHALL:
- pulse timeout for one cycle;
- return to IDLE;
- clear locked and the match counter;
- not produce a result.
REQ-025 Cycles with s_valid=0 SHALL change no state.

Reset
REQ-026 rst=1 SHALL set the FSM to IDLE in the next cycle and clear the following:
- m_valid, locked, timeout, drop_cnt, prev_valid and the match counter all set to 0;
- m_period, m_min and m_max set to 0.
REQ-027 rst SHALL take priority over every event in the same cycle, including a mid-measurement or pending result, which is lost.

Configuration
REQ-028 Macro SAW_ANALYZER_MINMAX_EN SHALL select whether min/max tracking is built.
- Defined: min/max tracking is built and m_min/m_max behave as REQ-012.
- Undefined: no min/max registers are built; m_min=8'h00 and m_max=8'hFF constantly; period and lock behaviour are unchanged.

Verification
REQ-029 Ideal ramp 0x00,0x02,...,0xFE repeated, continuous valid, m_ready=1 -> each result m_period=128, m_min=0x00, m_max=0xFE; locked=1 after the 3rd result.
REQ-030 Sequence 0x80 -> 0x01 (drop 127) -> no wrap; sequence 0x80 -> 0x00 (drop 128) -> wrap.
REQ-031 Ramp as REQ-029 with m_ready=0 across two wraps -> first result held unchanged, second discarded, drop_cnt=1; with m_ready=1 during the second wrap -> drop_cnt=0.
REQ-032 PER_W=8: wrap, then constant 0x40 -> timeout pulses once when cnt=255, FSM returns to IDLE, locked=0, no m_valid.
REQ-033 Periods 128,128,128,100 -> locked rises after the third result and falls after the 100 result.
REQ-034 rst asserted 50 samples into a period with a result pending -> next cycle m_valid=0, drop_cnt=0, locked=0; the next wrap only re-enters MEASURE.
